// File: rtl/bias_pkg.sv
// Shared types and helpers for the bias-add stage.
// Holds the FSM encoding, per-layer defaults and the clamp function.
package bias_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int DEF_NUM_CH  = 64;
  localparam int DEF_BIAS_W  = 32;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_OUT_W   = 16;

  localparam int CONV_NUM_CH = 64;
  localparam int FIRE_NUM_CH = 48;

  localparam int SAT_MAX_W   = 64;

  // Sign-extends x from in_w bits, then clamps to a signed out_w range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input logic signed [SAT_MAX_W-1:0] x,
    input int                          in_w,
    input int                          out_w
  );
    logic signed [SAT_MAX_W-1:0] v;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    v  = (x <<< (SAT_MAX_W - in_w)) >>> (SAT_MAX_W - in_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/bias_sat_add.sv
// Combinational sign-extend, add, optional ReLU and saturate.
// Shared with other activation paths.
module bias_sat_add
  import bias_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int BIAS_W = DEF_BIAS_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [BIAS_W-1:0] bias,
  input  logic              relu_en,
  output logic [OUT_W-1:0]  res
);

  localparam int S = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;

  logic signed [S-1:0]         acc_x;
  logic signed [S-1:0]         bias_x;
  logic signed [S-1:0]         sum;
  logic signed [SAT_MAX_W-1:0] wide;

  always_comb begin
    acc_x  = {{(S-ACC_W){acc[ACC_W-1]}}, acc};
    bias_x = {{(S-BIAS_W){bias[BIAS_W-1]}}, bias};
    sum    = acc_x + bias_x;
    if (relu_en && sum[S-1]) begin
      sum = '0;
    end
    wide = {{(SAT_MAX_W-S){sum[S-1]}}, sum};
    res  = OUT_W'(sat_clamp(wide, S, OUT_W));
  end

endmodule

// File: rtl/bias_unit.sv
// Runtime-loadable bias store with a one-cycle bias-add stage.
// Loaded over ld_*, then adds bias, ReLU and saturation per acc word.
module bias_unit
  import bias_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int BIAS_W  = DEF_BIAS_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [BIAS_W-1:0] ld_data,
  output logic              loaded,
  input  logic              relu_en,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ACC_W-1:0]  acc_data,
  input  logic [CH_W-1:0]   acc_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              ch_err
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  logic [BIAS_W-1:0] bias_mem [NUM_CH];

  state_t            state;
  logic [CH_W-1:0]   wr_ptr;
  logic              ld_fire;
  logic              acc_fire;
  logic              ch_ok;
  logic [BIAS_W-1:0] bias_sel;
  logic [OUT_W-1:0]  sum_sat;

  assign ld_ready  = (state == ST_LOAD) && !load_start;
  assign acc_ready = (state == ST_RUN) && !load_start &&
                     (!out_valid || out_ready);
  assign ld_fire   = ld_valid && ld_ready;
  assign acc_fire  = acc_valid && acc_ready;

  // Out-of-range channels only exist for non power-of-2 NUM_CH.
  assign ch_ok    = 32'(acc_ch) < NUM_CH;
  assign bias_sel = ch_ok ? bias_mem[acc_ch] : '0;

  bias_sat_add #(
    .ACC_W  (ACC_W),
    .BIAS_W (BIAS_W),
    .OUT_W  (OUT_W)
  ) u_sat_add (
    .acc     (acc_data),
    .bias    (bias_sel),
    .relu_en (relu_en),
    .res     (sum_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bias_mem[i] <= '0;
      end
    end else if (ld_fire) begin
      bias_mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      loaded <= 1'b0;
    end else if (load_start) begin
      state  <= ST_LOAD;
      wr_ptr <= '0;
      loaded <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (ld_fire) begin
            if (wr_ptr == LAST) begin
              state  <= ST_RUN;
              loaded <= 1'b1;
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_IDLE, ST_RUN: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A held result drains independently of load_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ch_err    <= 1'b0;
    end else begin
      if (load_start) begin
        ch_err <= 1'b0;
      end else if (acc_fire && !ch_ok) begin
        ch_err <= 1'b1;
      end
      if (acc_fire) begin
        out_valid <= 1'b1;
        out_data  <= sum_sat;
        out_ch    <= acc_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_unit.sv
// Scoreboard bench for bias_unit: directed vectors, queue-based monitor.
// A second NUM_CH=48 instance covers the out-of-range channel path.
module tb_bias_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        load_start, ld_valid, ld_ready, loaded;
  logic [31:0] ld_data;
  logic        relu_en, acc_valid, acc_ready;
  logic [31:0] acc_data;
  logic [5:0]  acc_ch;
  logic        out_valid, out_ready, ch_err;
  logic [15:0] out_data;
  logic [5:0]  out_ch;

  logic        load_start_b, ld_valid_b, ld_ready_b, loaded_b;
  logic [31:0] ld_data_b;
  logic        relu_en_b, acc_valid_b, acc_ready_b;
  logic [31:0] acc_data_b;
  logic [5:0]  acc_ch_b;
  logic        out_valid_b, out_ready_b, ch_err_b;
  logic [15:0] out_data_b;
  logic [5:0]  out_ch_b;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  typedef struct packed {
    logic [15:0] d;
    logic [5:0]  ch;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  bias_unit dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .loaded(loaded), .relu_en(relu_en), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_data(acc_data), .acc_ch(acc_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .ch_err(ch_err)
  );

  bias_unit #(.NUM_CH(48)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_start(load_start_b),
    .ld_valid(ld_valid_b), .ld_ready(ld_ready_b),
    .ld_data(ld_data_b), .loaded(loaded_b), .relu_en(relu_en_b),
    .acc_valid(acc_valid_b), .acc_ready(acc_ready_b),
    .acc_data(acc_data_b), .acc_ch(acc_ch_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_ch(out_ch_b), .ch_err(ch_err_b)
  );

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (run_chk)
        chk("acc_ready_mirror", acc_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d expected none",
                   $signed(out_data));
        end else begin
          chk("out_data", $signed(out_data), $signed(sbq[0].d));
          chk("out_ch", out_ch, sbq[0].ch);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] bval(input int which, input int i);
    if (which == 1) return 32'(1000 - 7 * i);
    case (i)
      0:       return 32'hFFFF_FF45;
      5:       return 32'(-300);
      37:      return 32'd1357;
      63:      return 32'd77;
      default: return 32'd0;
    endcase
  endfunction

  task automatic send_acc(input logic signed [31:0] d, input int ch,
                          input logic relu,
                          input logic signed [15:0] exp);
    int n;
    exp_t e;
    acc_valid = 1'b1;
    acc_data  = d;
    acc_ch    = 6'(ch);
    relu_en   = relu;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_ready && n < 200);
    if (!acc_ready) begin
      fail_now("acc_handshake");
    end else begin
      e.d  = exp;
      e.ch = 6'(ch);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    acc_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sbq.size() != 0 || out_valid) && n < 200);
    if (sbq.size() != 0 || out_valid) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic load_seq(input int which);
    int n;
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = bval(which, i);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ld_ready && n < 50);
      if (!ld_ready) begin
        fail_now("ld_handshake");
        ld_valid = 1'b0;
        return;
      end
      if (i == 0 || i == 63) begin
        chk("loaded_low", loaded, 0);
        chk("acc_ready_in_load", acc_ready, 0);
      end
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    chk("loaded_high", loaded, 1);
    chk("ld_ready_fall", ld_ready, 0);
    chk("acc_ready_first", acc_ready, 1);
  endtask

  int          t_d  [11] = '{1000, 0, 40000, -40000, -5, 5, 1000,
                             32'h7FFF_FFFF, 32'h8000_0000,
                             32689, -32582};
  int          t_ch [11] = '{0, 37, 1, 1, 1, 0, 5, 63, 0, 63, 0};
  bit          t_rl [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  int          t_ex [11] = '{813, 1357, 32767, -32768, 0, 0, 700,
                             32767, -32768, 32766, -32768};
  int          bp_ex [8] = '{-187, 100, 200, 300, 400, 200, 600, 700};
  bit          pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    load_start = 0; ld_valid = 0; ld_data = 0; relu_en = 0;
    acc_valid = 0; acc_data = 0; acc_ch = 0; out_ready = 1;
    load_start_b = 0; ld_valid_b = 0; ld_data_b = 0;
    relu_en_b = 0; acc_valid_b = 0; acc_data_b = 0;
    acc_ch_b = 0; out_ready_b = 1;

    #12;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_acc_ready", acc_ready, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_ch_err", ch_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ld_ready", ld_ready, 0);
    chk("idle_acc_ready", acc_ready, 0);

    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_seq(0);
    for (int i = 0; i < 11; i++)
      send_acc(t_d[i], t_ch[i], t_rl[i], 16'(t_ex[i]));
    drain();

    run_chk = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_acc(i * 100, i, 1'b0, 16'(bp_ex[i]));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    run_chk = 1'b0;

    out_ready = 1'b0;
    send_acc(1, 37, 1'b0, 16'sd1358);
    @(negedge clk);
    chk("held_valid", out_valid, 1);
    @(posedge clk); #1;
    load_start = 1'b1;
    @(negedge clk);
    chk("run_restart_acc_ready", acc_ready, 0);
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("restart_loaded", loaded, 0);
    chk("restart_ch_err", ch_err, 0);
    chk("restart_held", out_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("held_delivered", out_valid, 0);
    chk("held_queue", sbq.size(), 0);

    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = bval(0, i);
      @(posedge clk); #1;
    end
    ld_data    = 32'd12345;
    load_start = 1'b1;
    @(negedge clk);
    chk("restart_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    load_start = 1'b0;
    load_seq(1);
    send_acc(0, 0, 1'b0, 16'sd1000);
    send_acc(0, 1, 1'b0, 16'sd993);
    send_acc(0, 5, 1'b0, 16'sd965);
    send_acc(0, 63, 1'b0, 16'sd559);
    drain();

    load_start_b = 1'b1;
    @(posedge clk); #1;
    load_start_b = 1'b0;
    ld_valid_b = 1'b1;
    n = 0;
    while (!loaded_b && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ld_valid_b = 1'b0;
    chk("b_loaded", loaded_b, 1);
    chk("b_load_cycles", n, 48);
    acc_valid_b = 1'b1;
    acc_data_b  = 32'd7;
    acc_ch_b    = 6'd50;
    @(negedge clk);
    chk("b_acc_ready", acc_ready_b, 1);
    @(posedge clk); #1;
    acc_valid_b = 1'b0;
    chk("b_out_valid", out_valid_b, 1);
    chk("b_out_data", out_data_b, 7);
    chk("b_out_ch", out_ch_b, 50);
    chk("b_ch_err", ch_err_b, 1);
    acc_valid_b = 1'b1;
    acc_data_b  = 32'd9;
    acc_ch_b    = 6'd3;
    @(posedge clk); #1;
    acc_valid_b = 1'b0;
    chk("b_out_data2", out_data_b, 9);
    chk("b_ch_err_sticky", ch_err_b, 1);
    load_start_b = 1'b1;
    @(posedge clk); #1;
    load_start_b = 1'b0;
    chk("b_ch_err_clr", ch_err_b, 0);
    chk("b_loaded_clr", loaded_b, 0);

    out_ready = 1'b0;
    send_acc(100, 1, 1'b0, 16'sd1093);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_ch", out_ch, 0);
    chk("arst_loaded", loaded, 0);
    chk("arst_ld_ready", ld_ready, 0);
    chk("arst_acc_ready", acc_ready, 0);
    chk("arst_b_out_valid", out_valid_b, 0);
    chk("arst_b_loaded", loaded_b, 0);
    sbq.delete();
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bias_unit.md
# bias_unit

Runtime-loadable, parametrised bias store with a streaming bias-add stage for the conv/fire layers. It replaces per-layer hard-wired bias constant blocks: one `bias_unit` instance per layer engine is loaded with that layer's NUM_CH biases over a valid/ready stream. It then adds the selected channel's bias to each accumulator result, applies optional ReLU, and saturates to the output activation width. It sits between the MAC accumulator output and the activation writeback path.

## Interface
- NUM_CH, 64, number of output channels / bias entries
- BIAS_W, 32, bias word width, signed two's complement
- ACC_W, 32, accumulator input width, signed
- OUT_W, 16, output activation width, signed
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse: restart bias load at entry 0
- ld_valid  in  1  bias word valid
- ld_ready  out  1  bias word accepted when ld_valid&&ld_ready
- ld_data  in  BIAS_W  bias word, entries written in ascending index order
- loaded  out  1  all NUM_CH entries written since last load_start
- relu_en  in  1  clamp negative sums to 0 before saturation (sampled with acc transfer)
- acc_valid  in  1  accumulator result valid
- acc_ready  out  1  accumulator result accepted when acc_valid&&acc_ready
- acc_data  in  ACC_W  accumulator result
- acc_ch  in  CH_W  channel index of acc_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- out_data  out  OUT_W  biased, activated, saturated result
- out_ch  out  CH_W  channel index of out_data
- ch_err  out  1  sticky: acc_ch >= NUM_CH was accepted; cleared by load_start

## Operation
- FSM states: IDLE (after reset), LOAD, RUN.
- IDLE: ld_ready=0, acc_ready=0. On load_start, go to LOAD with wr_ptr=0 and loaded=0.
- LOAD: ld_ready=1 except in a cycle where load_start=1. Each transfer writes bias[wr_ptr] and increments wr_ptr. The transfer with wr_ptr==NUM_CH-1 moves the FSM to RUN and sets loaded=1 on the same edge.
- RUN: ld_ready=0. acc_ready = !out_valid || out_ready (single-entry output register, full throughput).
- load_start in any state returns the FSM to LOAD, resets wr_ptr and clears loaded and ch_err.
- A pending out_valid result is held until it is consumed; it is never dropped. No new acc transfers occur until RUN is re-entered.
- Arithmetic:
  - S = max(ACC_W,BIAS_W)+1.
  - sum = sext_S(acc_data) + sext_S(bias[acc_ch]).
  - If relu_en and sum<0, sum=0.
  - out_data = sum clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- acc_ch >= NUM_CH (only possible when NUM_CH is not a power of 2): bias is treated as 0, the result is still produced, and ch_err is set.
- Reset values: all bias entries 0, state IDLE, wr_ptr 0, loaded 0, ch_err 0, out_valid 0, out_data 0, out_ch 0. ld_ready and acc_ready are 0 during and after reset.

## Timing
- Bias-add latency: 1 cycle. An acc transfer at edge N gives out_valid=1 with the result after edge N.
- out_data and out_ch are registered and held stable while out_valid&&!out_ready.
- Simultaneous consume and accept: the output register reloads on the same edge, with no bubble.
- Load: NUM_CH transfers minimum, one per cycle when ld_valid is held high.
- ld_ready falls the cycle after the last entry is written.
- First acc_ready=1 occurs the cycle after loaded rises.
- load_start coinciding with ld_valid: that word is not accepted (ld_ready=0) and entry 0 is written by the next transfer.
- Asynchronous reset mid-load or mid-run: immediate return to reset values, and the bias contents are lost.

## Structure
- Shared package `bias_pkg`:
  - FSM state enum
  - saturate/clamp function, parametrised on input and output width
  - default NUM_CH/BIAS_W/OUT_W constants per layer
- One natural sub-module, `bias_sat_add`: combinational sign-extend, add, ReLU and saturate, reused by other activation paths.
- The bias store is a flop array (NUM_CH×BIAS_W), not SRAM, so the read is combinational within the add cycle.

## Test plan
- Reset, load_start, then 64 words with bias[0]=-187 (0xFFFFFF45) and bias[37]=1357. Then acc_data=1000 with acc_ch=0 → out_data=813, and acc_data=0 with acc_ch=37 → out_data=1357. loaded rises on the 64th transfer.
- Saturation, OUT_W=16, bias=0: acc=40000 → 32767; acc=-40000 → -32768; acc=-5 with relu_en=1 → 0.
- Backpressure: stream 8 acc results while out_ready toggles 1,0,0,1… → every result is delivered exactly once, in order. acc_ready mirrors !out_valid||out_ready, and out_data is stable while stalled.
- load_start mid-load after 10 words, with ld_valid held high → the word in the load_start cycle is rejected, and the next 64 words land at entries 0..63. loaded stays 0 until the 64th word.
- load_start in RUN with a stalled output → the held result is delivered after out_ready, acc_ready stays 0 until reload completes, and ch_err and loaded clear.
- NUM_CH=48 build: acc_ch=50 with acc=7 → out_data=7 and ch_err=1 sticky. rst_n low mid-stream → all outputs 0 asynchronously.
